// File: rtl/cpu_reg_pkg.sv
// Shared register-map constants and byte-merge helper for the CPU register bank.
package cpu_reg_pkg;

    localparam int unsigned OFF_CTRL     = 0;
    localparam int unsigned OFF_FRAMELEN = 1;
    localparam int unsigned OFF_BLANKLEN = 2;
    localparam int unsigned OFF_TOTALNUM = 3;
    localparam int unsigned OFF_CUTNUM   = 4;
    localparam int unsigned OFF_COMMIT   = 5;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_START   = 1;
    localparam int unsigned CTRL_STOP    = 2;
    localparam int unsigned CTRL_CLRFIFO = 3;

    localparam int unsigned STATUS_ADDR  = 0;

    localparam int unsigned PULSE_CNT_W  = 8;

    // Replace only the bytes of old_v whose enable bit is set.
    function automatic logic [31:0] be_merge32(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_reg_bank_if.sv
// Asynchronous-strobe CPU bus between a host and the channel register bank.
interface cpu_reg_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
);
    logic                  cpu_wr_n;
    logic                  cpu_rd_n;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W/8-1:0]   cpu_be;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_rvalid;

    modport master (
        output cpu_wr_n, cpu_rd_n, cpu_addr, cpu_be, cpu_wdata,
        input  cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_wr_n, cpu_rd_n, cpu_addr, cpu_be, cpu_wdata,
        output cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/cpu_reg_bank_cmd_pulse_gen.sv
// Retriggerable fixed-length command pulse; a fire reloads the counter.
module cmd_pulse_gen
    import cpu_reg_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic clk,
    input  logic pRST,
    input  logic fire,
    output logic pulse
);
    logic [PULSE_CNT_W-1:0] count;

    // pulse tracks (count != 0) but is kept as its own flop for a clean output
    always_ff @(posedge clk or posedge pRST) begin
        if (pRST) begin
            count <= '0;
            pulse <= 1'b0;
        end else if (fire) begin
            count <= PULSE_CNT_W'(PULSE_LEN);
            pulse <= 1'b1;
        end else if (count != '0) begin
            count <= count - PULSE_CNT_W'(1);
            pulse <= (count != PULSE_CNT_W'(1));
        end
    end
endmodule

// File: rtl/cpu_reg_bank.sv
// Per-channel control/shadow/active register bank behind an edge-strobed CPU bus.
module cpu_reg_bank
    import cpu_reg_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned CH_BASE   = 20,
    parameter int unsigned CH_STRIDE = 16,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic                   clk,
    input  logic                   pRST,
    cpu_reg_bank_if.slave          bus,
    output logic [NUM_CH-1:0]      ch_enable,
    output logic [NUM_CH-1:0]      ch_start,
    output logic [NUM_CH-1:0]      ch_stop,
    output logic [NUM_CH-1:0]      ch_clrfifo,
    output logic [16*NUM_CH-1:0]   ch_framelen,
    output logic [16*NUM_CH-1:0]   ch_blanklen,
    output logic [32*NUM_CH-1:0]   ch_totalnum,
    output logic [32*NUM_CH-1:0]   ch_cutnum,
    output logic [NUM_CH-1:0]      ch_commit,
    output logic                   error
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned OFF_W = $clog2(CH_STRIDE);
    localparam int unsigned DEC_W = 1 + CH_W + OFF_W;

    // {hit, channel, offset}; hit only for the six implemented offsets
    function automatic logic [DEC_W-1:0] decode(input logic [ADDR_W-1:0] a);
        int unsigned rel;
        logic        hit;
        rel = 32'(a) - 32'(CH_BASE);
        hit = (32'(a) >= 32'(CH_BASE)) &&
              (rel < 32'(NUM_CH * CH_STRIDE)) &&
              ((rel % CH_STRIDE) <= OFF_COMMIT);
        return {hit, CH_W'(rel / CH_STRIDE), OFF_W'(rel % CH_STRIDE)};
    endfunction

    logic                wr_n_q, rd_n_q;
    logic                wr_fire, rd_fire;
    logic                rd_pend;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [ADDR_W-1:0]   bad_addr;

    logic                w_hit, r_hit;
    logic [CH_W-1:0]     w_ch, r_ch;
    logic [OFF_W-1:0]    w_off, r_off;
    logic                w_status, w_bad;
    logic [31:0]         wdata32;
    logic [3:0]          be4;

    logic [NUM_CH-1:0]   fire_start, fire_stop, fire_clr, commit_c;
    logic [DATA_W-1:0]   rd_data_c;

    logic [15:0]         sh_frame [NUM_CH];
    logic [15:0]         sh_blank [NUM_CH];
    logic [31:0]         sh_total [NUM_CH];
    logic [31:0]         sh_cut   [NUM_CH];

    assign wr_fire  = wr_n_q & ~bus.cpu_wr_n;
    assign rd_fire  = rd_n_q & ~bus.cpu_rd_n;
    assign wdata32  = 32'(bus.cpu_wdata);
    assign be4      = 4'(bus.cpu_be);
    assign {w_hit, w_ch, w_off} = decode(bus.cpu_addr);
    assign w_status = (bus.cpu_addr == ADDR_W'(STATUS_ADDR));
    assign w_bad    = wr_fire & ~w_hit & ~w_status;

    // A read deferred by a colliding write keeps its own captured address
    assign rd_addr_c = rd_pend ? rd_addr_q : bus.cpu_addr;
    assign {r_hit, r_ch, r_off} = decode(rd_addr_c);

    // Command fires and commit strobes for the current write
    always_comb begin
        fire_start = '0;
        fire_stop  = '0;
        fire_clr   = '0;
        commit_c   = '0;
        if (wr_fire && w_hit) begin
            case (w_off)
                OFF_W'(OFF_CTRL): begin
                    fire_start[w_ch] = wdata32[CTRL_START] & ~wdata32[CTRL_STOP];
                    fire_stop[w_ch]  = wdata32[CTRL_STOP];
                    fire_clr[w_ch]   = wdata32[CTRL_CLRFIFO];
                end
                OFF_W'(OFF_COMMIT): commit_c[w_ch] = wdata32[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data_c = '0;
        if (rd_addr_c == ADDR_W'(STATUS_ADDR)) begin
            rd_data_c = DATA_W'({bad_addr, error});
        end else if (r_hit) begin
            case (r_off)
                OFF_W'(OFF_CTRL):     rd_data_c = DATA_W'({ch_clrfifo[r_ch], ch_stop[r_ch],
                                                           ch_start[r_ch], ch_enable[r_ch]});
                OFF_W'(OFF_FRAMELEN): rd_data_c = DATA_W'(sh_frame[r_ch]);
                OFF_W'(OFF_BLANKLEN): rd_data_c = DATA_W'(sh_blank[r_ch]);
                OFF_W'(OFF_TOTALNUM): rd_data_c = DATA_W'(sh_total[r_ch]);
                OFF_W'(OFF_CUTNUM):   rd_data_c = DATA_W'(sh_cut[r_ch]);
                default:              rd_data_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge pRST) begin
        if (pRST) begin
            wr_n_q         <= 1'b0;
            rd_n_q         <= 1'b0;
            rd_pend        <= 1'b0;
            rd_addr_q      <= '0;
            bus.cpu_rdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
            error          <= 1'b0;
            bad_addr       <= '0;
            ch_enable      <= '0;
            ch_commit      <= '0;
            ch_framelen    <= '0;
            ch_blanklen    <= '0;
            ch_totalnum    <= '0;
            ch_cutnum      <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sh_frame[ch] <= '0;
                sh_blank[ch] <= '0;
                sh_total[ch] <= '0;
                sh_cut[ch]   <= '0;
            end
        end else begin
            wr_n_q    <= bus.cpu_wr_n;
            rd_n_q    <= bus.cpu_rd_n;
            ch_commit <= commit_c;

            // Write wins a same-cycle collision; the read answers a cycle later
            rd_pend        <= rd_fire & wr_fire;
            bus.cpu_rvalid <= (rd_fire & ~wr_fire) | rd_pend;
            bus.cpu_rdata  <= ((rd_fire & ~wr_fire) | rd_pend) ? rd_data_c : '0;
            if (rd_fire) rd_addr_q <= bus.cpu_addr;

            if (w_bad) begin
                error    <= 1'b1;
                bad_addr <= bus.cpu_addr;
            end else if (wr_fire && w_status && wdata32[0]) begin
                error    <= 1'b0;
            end

            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_fire && w_hit && (w_ch == CH_W'(ch))) begin
                    case (w_off)
                        OFF_W'(OFF_CTRL):     ch_enable[ch] <= wdata32[CTRL_EN];
                        OFF_W'(OFF_FRAMELEN): sh_frame[ch]  <= 16'(be_merge32(32'(sh_frame[ch]), wdata32, be4));
                        OFF_W'(OFF_BLANKLEN): sh_blank[ch]  <= 16'(be_merge32(32'(sh_blank[ch]), wdata32, be4));
                        OFF_W'(OFF_TOTALNUM): sh_total[ch]  <= be_merge32(sh_total[ch], wdata32, be4);
                        OFF_W'(OFF_CUTNUM):   sh_cut[ch]    <= be_merge32(sh_cut[ch], wdata32, be4);
                        default: ;
                    endcase
                end
                if (commit_c[ch]) begin
                    ch_framelen[16*ch +: 16] <= sh_frame[ch];
                    ch_blanklen[16*ch +: 16] <= sh_blank[ch];
                    ch_totalnum[32*ch +: 32] <= sh_total[ch];
                    ch_cutnum[32*ch +: 32]   <= sh_cut[ch];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cmd_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_start (
            .clk(clk), .pRST(pRST), .fire(fire_start[g]), .pulse(ch_start[g]));
        cmd_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_stop (
            .clk(clk), .pRST(pRST), .fire(fire_stop[g]),  .pulse(ch_stop[g]));
        cmd_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_clr (
            .clk(clk), .pRST(pRST), .fire(fire_clr[g]),   .pulse(ch_clrfifo[g]));
    end
endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed-vector bench for cpu_reg_bank with hand-computed expectations.
module tb_cpu_reg_bank;
    logic         clk = 1'b0;
    logic         pRST = 1'b1;
    logic [3:0]   ch_enable, ch_start, ch_stop, ch_clrfifo, ch_commit;
    logic [63:0]  ch_framelen, ch_blanklen;
    logic [127:0] ch_totalnum, ch_cutnum;
    logic         error;
    int           checks = 0;
    int           failures = 0;
    int           cnt_a, cnt_b;

    cpu_reg_bank_if #(.DATA_W(32), .ADDR_W(9)) bus ();

    cpu_reg_bank dut (
        .clk(clk), .pRST(pRST), .bus(bus),
        .ch_enable(ch_enable), .ch_start(ch_start), .ch_stop(ch_stop),
        .ch_clrfifo(ch_clrfifo), .ch_framelen(ch_framelen),
        .ch_blanklen(ch_blanklen), .ch_totalnum(ch_totalnum),
        .ch_cutnum(ch_cutnum), .ch_commit(ch_commit), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_be    = be;
        bus.cpu_wr_n  = 1'b0;
        tick();
        bus.cpu_wr_n  = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [8:0] a, input logic [31:0] exp);
        bus.cpu_addr = a;
        bus.cpu_rd_n = 1'b0;
        tick();
        check(tag, {bus.cpu_rvalid, bus.cpu_rdata}, {1'b1, exp});
        bus.cpu_rd_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.cpu_wr_n = 1'b1;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_addr = '0;
        bus.cpu_be = '0;
        bus.cpu_wdata = '0;
        tick();
        tick();
        check("rst_ctrl_outs", {ch_enable, ch_start, ch_stop, ch_clrfifo, ch_commit, error, bus.cpu_rvalid}, 0);
        check("rst_active", (ch_framelen == '0) && (ch_totalnum == '0), 1);
        pRST = 1'b0;
        tick();
        tick();

        // Shadow write, read-back, then commit to active
        wr(9'd37, 32'h1234, 4'hF);
        tick();
        check("fl1_before_commit", ch_framelen[31:16], 0);
        rd_chk("rd_fl1_shadow", 9'd37, 32'h1234);
        wr(9'd41, 32'h1, 4'hF);
        check("fl1_active", ch_framelen[31:16], 16'h1234);
        check("commit_strobe", ch_commit, 4'b0010);
        tick();
        check("commit_one_cycle", ch_commit, 0);
        check("rvalid_idle", bus.cpu_rvalid, 0);

        // Start pulse length and refire
        wr(9'd20, 32'h2, 4'hF);
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin cnt_a += int'(ch_start[0]); tick(); end
        check("start_len", cnt_a, 4);
        tick();
        wr(9'd20, 32'h2, 4'hF);
        cnt_a = int'(ch_start[0]);
        tick();
        cnt_a += int'(ch_start[0]);
        wr(9'd20, 32'h2, 4'hF);
        for (int i = 0; i < 8; i++) begin cnt_a += int'(ch_start[0]); tick(); end
        check("start_refire_len", cnt_a, 6);
        tick();

        // Start and stop together: only stop fires
        wr(9'd20, 32'h6, 4'hF);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            cnt_a += int'(ch_start[0]);
            cnt_b += int'(ch_stop[0]);
            tick();
        end
        check("start_suppressed", cnt_a, 0);
        check("stop_len", cnt_b, 4);

        // Strobe held low for 10 cycles gives a single pulse
        bus.cpu_addr = 9'd20;
        bus.cpu_wdata = 32'h8;
        bus.cpu_be = 4'hF;
        bus.cpu_wr_n = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) bus.cpu_wr_n = 1'b1;
            cnt_a += int'(ch_clrfifo[0]);
            tick();
        end
        check("held_wr_single", cnt_a, 4);

        wr(9'd20, 32'h1, 4'hF);
        tick();
        check("enable_level", ch_enable, 4'b0001);
        rd_chk("rd_ctrl", 9'd20, 32'h1);

        // Byte enables and field truncation
        wr(9'd23, 32'hAABBCCDD, 4'b0101);
        tick();
        rd_chk("rd_total_be", 9'd23, 32'h00BB00DD);
        wr(9'd21, 32'hFFFF5678, 4'hF);
        tick();
        rd_chk("rd_fl0_trunc", 9'd21, 32'h5678);
        wr(9'd25, 32'h1, 4'hF);
        check("total0_active", ch_totalnum[31:0], 32'h00BB00DD);
        check("fl0_active", ch_framelen[15:0], 16'h5678);
        tick();
        wr(9'd21, 32'h1111, 4'hF);
        tick();
        wr(9'd25, 32'h0, 4'hF);
        check("commit_bit0_zero", {ch_commit, ch_framelen[15:0]}, {4'b0000, 16'h5678});
        tick();

        // Bad access, STATUS read and clear
        wr(9'd7, 32'h0, 4'hF);
        tick();
        check("err_set_7", error, 1);
        rd_chk("rd_status_7", 9'd0, 32'h0F);
        wr(9'd0, 32'h1, 4'hF);
        tick();
        check("err_w1c", error, 0);
        rd_chk("rd_unmapped", 9'd30, 32'h0);
        check("read_no_err", error, 0);
        wr(9'd30, 32'hFFFF, 4'hF);
        tick();
        rd_chk("rd_status_30", 9'd0, 32'h3D);
        wr(9'd0, 32'h1, 4'hF);
        tick();

        // Simultaneous strobes: write first, read a cycle later
        bus.cpu_addr = 9'd22;
        bus.cpu_wdata = 32'hBEEF;
        bus.cpu_be = 4'hF;
        bus.cpu_wr_n = 1'b0;
        bus.cpu_rd_n = 1'b0;
        tick();
        check("collide_no_rvalid", bus.cpu_rvalid, 0);
        bus.cpu_wr_n = 1'b1;
        bus.cpu_rd_n = 1'b1;
        tick();
        check("collide_rd", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b1, 32'hBEEF});
        tick();
        check("collide_rvalid_drop", bus.cpu_rvalid, 0);

        // Reset in the middle of a pulse
        wr(9'd9, 32'h0, 4'hF);
        tick();
        wr(9'd20, 32'h3, 4'hF);
        check("pre_rst_start", ch_start[0], 1);
        tick();
        pRST = 1'b1;
        #1;
        check("rst_mid_ctrl", {ch_enable, ch_start, ch_stop, ch_clrfifo, ch_commit, error, bus.cpu_rvalid}, 0);
        check("rst_mid_active", (ch_framelen == '0) && (ch_totalnum == '0), 1);
        tick();
        tick();
        pRST = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin cnt_a += int'(ch_start[0]) + int'(ch_enable[0]); tick(); end
        check("no_pulse_after_rst", cnt_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
